// File: rtl/psum_pkg.sv
// Shared FSM encoding, default datapath widths and the one-lane requantizer for psum_accum_buffer.
// The ReLU behaviour is selected by the caller (see PSUMBUF_RELU_EN in psum_requant_lane).
package psum_pkg;

  localparam int ARRAY_DIM = 16;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 8;

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Round half up, arithmetic shift in ACC_W+1 bits so the rounding add cannot overflow, then clamp.
  function automatic logic [OUT_W-1:0] requant_lane(input logic [ACC_W-1:0] acc,
                                                    input logic [4:0]       shift,
                                                    input logic             relu_en);
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] v;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    hi   = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    lo   = ~hi;
    wide = $signed({acc[ACC_W-1], acc});
    rnd  = '0;
    if (shift != 5'd0) begin
      rnd[shift - 5'd1] = 1'b1;
    end
    v = (wide + rnd) >>> shift;
    if (relu_en && v[ACC_W]) begin
      v = '0;
    end
    if (v > hi) begin
      v = hi;
    end else if (v < lo) begin
      v = lo;
    end
    return v[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_requant_lane.sv
// One output lane: round, arithmetic shift, optional ReLU and saturation to a signed OUT_W value.
// Define PSUMBUF_RELU_EN to force negative lanes to zero (output range [0, 127]).
module psum_requant_lane
  import psum_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [4:0]       shift,
  output logic [OUT_W-1:0] q
);

`ifdef PSUMBUF_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif

  assign q = requant_lane(acc, shift, RELU);

endmodule

// File: rtl/psum_accum_buffer.sv
// Partial-sum buffer: read-modify-write accumulation of PE vectors into on-chip RAM, then a
// valid/ready drain of requantized vectors. Build option: PSUMBUF_RELU_EN (see psum_requant_lane).
module psum_accum_buffer
  import psum_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       acc_enable,
  input  logic                       acc_clear,
  input  logic [AW-1:0]              acc_addr,
  input  logic [ARRAY_DIM*ACC_W-1:0] pe_acc_out,
  input  logic                       conv_done,
  input  logic [AW:0]                drain_len,
  input  logic [4:0]                 shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ARRAY_DIM*OUT_W-1:0] out_data,
  output logic [AW-1:0]              out_addr,
  output logic                       out_last,
  output logic                       drain_done,
  output logic                       busy,
  output logic                       err
);

  localparam int VW = ARRAY_DIM*ACC_W;
  localparam int QW = ARRAY_DIM*OUT_W;

  logic [VW-1:0] mem [DEPTH];
  logic [VW-1:0] ram_rdata_q;
  logic [AW-1:0] ram_raddr;
  logic          ram_re;

  logic [1:0]  state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [4:0]  shift_q, shift_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        err_q, err_d;
  logic        drain_done_q, drain_done_d;

  logic          e0_valid_q, e0_valid_d;
  logic          e0_clear_q, e0_clear_d;
  logic [AW-1:0] e0_addr_q, e0_addr_d;
  logic [VW-1:0] e0_data_q, e0_data_d;
  logic          fwd_valid_q, fwd_valid_d;
  logic [AW-1:0] fwd_addr_q, fwd_addr_d;
  logic [VW-1:0] fwd_data_q, fwd_data_d;
  logic [VW-1:0] rmw_base;
  logic [VW-1:0] wr_data;
  logic          wr_fire;

  logic          rdv_q, rdv_d;
  logic          rd_last_q, rd_last_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [QW-1:0] rq_vec;

  logic [1:0][QW-1:0] fifo_data_q, fifo_data_d;
  logic [1:0][AW-1:0] fifo_addr_q, fifo_addr_d;
  logic [1:0]         fifo_last_q, fifo_last_d;
  logic               wr_idx_q, wr_idx_d;
  logic               rd_idx_q, rd_idx_d;
  logic [1:0]         count_q, count_d;
  logic               issue;
  logic               pop;
  logic               push;

  assign out_valid  = (count_q != 2'd0);
  assign out_data   = fifo_data_q[rd_idx_q];
  assign out_addr   = fifo_addr_q[rd_idx_q];
  assign out_last   = out_valid && fifo_last_q[rd_idx_q];
  assign drain_done = drain_done_q;
  assign err        = err_q;
  assign busy       = (state_q != S_ACCUM) || e0_valid_q;

  // The write lands in RAM on the edge that retires E0; the register behind it forwards that
  // result to the next E0 entry, whose RAM read was issued on that same edge and saw stale data.
  always_comb begin
    wr_fire     = acc_enable && (state_q == S_ACCUM);
    e0_valid_d  = wr_fire;
    e0_clear_d  = acc_clear;
    e0_addr_d   = acc_addr;
    e0_data_d   = pe_acc_out;
    rmw_base    = (fwd_valid_q && (fwd_addr_q == e0_addr_q)) ? fwd_data_q : ram_rdata_q;
    wr_data     = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      wr_data[i*ACC_W +: ACC_W] = e0_clear_q ? e0_data_q[i*ACC_W +: ACC_W]
                                             : rmw_base[i*ACC_W +: ACC_W] + e0_data_q[i*ACC_W +: ACC_W];
    end
    fwd_valid_d = e0_valid_q;
    fwd_addr_d  = e0_addr_q;
    fwd_data_d  = wr_data;
  end

  // A read may only issue if the 2-entry skid buffer is guaranteed room when it returns.
  always_comb begin
    pop       = out_valid && out_ready;
    push      = rdv_q;
    issue     = (state_q == S_DRAIN) && (rd_ptr_q < len_q) &&
                (({1'b0, count_q} + {2'b00, rdv_q}) <= (3'd1 + {2'b00, pop}));
    ram_re    = wr_fire || issue;
    ram_raddr = (state_q == S_DRAIN) ? rd_ptr_q[AW-1:0] : acc_addr;
    rdv_d     = issue;
    rd_addr_d = rd_ptr_q[AW-1:0];
    rd_last_d = (rd_ptr_q == len_q - 1'b1);

    fifo_data_d = fifo_data_q;
    fifo_addr_d = fifo_addr_q;
    fifo_last_d = fifo_last_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    if (push) begin
      fifo_data_d[wr_idx_q] = rq_vec;
      fifo_addr_d[wr_idx_q] = rd_addr_q;
      fifo_last_d[wr_idx_q] = rd_last_q;
      wr_idx_d              = ~wr_idx_q;
    end
    if (pop) begin
      rd_idx_d = ~rd_idx_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    shift_d      = shift_q;
    rd_ptr_d     = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
    drain_done_d = 1'b0;
    err_d        = err_q || (acc_enable && (state_q != S_ACCUM));
    case (state_q)
      S_ACCUM: begin
        if (conv_done) begin
          len_d    = drain_len;
          shift_d  = shift;
          rd_ptr_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!e0_valid_q) begin
          rd_ptr_d = '0;
          if (len_q == '0) begin
            drain_done_d = 1'b1;
            state_d      = S_ACCUM;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          drain_done_d = 1'b1;
          state_d      = S_ACCUM;
        end
      end
      default: state_d = S_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ACCUM;
      len_q        <= '0;
      shift_q      <= '0;
      rd_ptr_q     <= '0;
      err_q        <= 1'b0;
      drain_done_q <= 1'b0;
      e0_valid_q   <= 1'b0;
      fwd_valid_q  <= 1'b0;
      rdv_q        <= 1'b0;
      fifo_data_q  <= '0;
      fifo_addr_q  <= '0;
      fifo_last_q  <= '0;
      wr_idx_q     <= 1'b0;
      rd_idx_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      rd_ptr_q     <= rd_ptr_d;
      err_q        <= err_d;
      drain_done_q <= drain_done_d;
      e0_valid_q   <= e0_valid_d;
      fwd_valid_q  <= fwd_valid_d;
      rdv_q        <= rdv_d;
      fifo_data_q  <= fifo_data_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_last_q  <= fifo_last_d;
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    e0_clear_q <= e0_clear_d;
    e0_addr_q  <= e0_addr_d;
    e0_data_q  <= e0_data_d;
    fwd_addr_q <= fwd_addr_d;
    fwd_data_q <= fwd_data_d;
    rd_addr_q  <= rd_addr_d;
    rd_last_q  <= rd_last_d;
  end

  always_ff @(posedge clk) begin
    if (ram_re) begin
      ram_rdata_q <= mem[ram_raddr];
    end
    if (e0_valid_q) begin
      mem[e0_addr_q] <= wr_data;
    end
  end

  for (genvar g = 0; g < ARRAY_DIM; g++) begin : g_lane
    psum_requant_lane u_lane (
      .acc   (ram_rdata_q[g*ACC_W +: ACC_W]),
      .shift (shift_q),
      .q     (rq_vec[g*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Randomized self-checking bench for psum_accum_buffer against an array-based reference model.
// Honours PSUMBUF_RELU_EN when computing expected output lanes.
`timescale 1ns/1ps
module tb_psum_accum_buffer;

  localparam int ARRAY_DIM = 16;
  localparam int ACC_W     = 32;
  localparam int OUT_W     = 8;
  localparam int DEPTH     = 1024;
  localparam int AW        = 10;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       acc_enable;
  logic                       acc_clear;
  logic [AW-1:0]              acc_addr;
  logic [ARRAY_DIM*ACC_W-1:0] pe_acc_out;
  logic                       conv_done;
  logic [AW:0]                drain_len;
  logic [4:0]                 shift;
  logic                       out_valid;
  logic                       out_ready;
  logic [ARRAY_DIM*OUT_W-1:0] out_data;
  logic [AW-1:0]              out_addr;
  logic                       out_last;
  logic                       drain_done;
  logic                       busy;
  logic                       err;

  int model_mem [DEPTH][ARRAY_DIM];
  int pe_vals [ARRAY_DIM];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  psum_accum_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .acc_enable (acc_enable),
    .acc_clear  (acc_clear),
    .acc_addr   (acc_addr),
    .pe_acc_out (pe_acc_out),
    .conv_done  (conv_done),
    .drain_len  (drain_len),
    .shift      (shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .drain_done (drain_done),
    .busy       (busy),
    .err        (err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int refRequant(input int acc, input int sh);
    longint v;
    v = acc;
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
`ifdef PSUMBUF_RELU_EN
    if (v < 0) v = 0;
`endif
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic logic [127:0] expVec(input int addr, input int sh);
    logic [127:0] e;
    int r;
    e = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      r = refRequant(model_mem[addr][i], sh);
      e[i*OUT_W +: OUT_W] = r[7:0];
    end
    return e;
  endfunction

  task automatic randVals();
    int mode;
    mode = $urandom_range(0, 2);
    for (int i = 0; i < ARRAY_DIM; i++) begin
      case (mode)
        0:       pe_vals[i] = $urandom_range(0, 3000) - 1500;
        1:       pe_vals[i] = int'($urandom);
        default: pe_vals[i] = $urandom_range(0, 2_000_000) - 1_000_000;
      endcase
    end
  endtask

  task automatic drivePe();
    for (int i = 0; i < ARRAY_DIM; i++) pe_acc_out[i*ACC_W +: ACC_W] = pe_vals[i];
  endtask

  // One accepted write in S_ACCUM; the model applies the clear/accumulate rule directly.
  task automatic applyStimulus(input int addr, input bit clr);
    acc_enable = 1'b1;
    acc_clear  = clr;
    acc_addr   = addr[AW-1:0];
    drivePe();
    for (int i = 0; i < ARRAY_DIM; i++)
      model_mem[addr][i] = clr ? pe_vals[i] : model_mem[addr][i] + pe_vals[i];
    @(posedge clk); #1;
    acc_enable = 1'b0;
    acc_clear  = 1'b0;
  endtask

  // rmode: 0 = always ready, 1 = toggling 1010..., 2 = random. inject drives a dropped write.
  task automatic runDrain(input int len, input int sh, input int rmode, input bit inject);
    int  beats;
    int  cyc;
    int  last_cyc;
    bit  done;
    bit  prev_stall;
    conv_done = 1'b1;
    drain_len = len[AW:0];
    shift     = sh[4:0];
    @(posedge clk); #1;
    conv_done = 1'b0;
    checkOutput("busy_after_conv", 128'(busy), 128'(1));
    beats = 0; cyc = 0; last_cyc = -10; done = 0; prev_stall = 0;
    while (!done && cyc < 10000) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && cyc == 1) begin
        randVals();
        acc_enable = 1'b1;
        acc_clear  = 1'b1;
        acc_addr   = 10'd2;
        drivePe();
      end
      if (inject && cyc == 2) acc_enable = 1'b0;
      if (prev_stall) checkOutput("valid_hold", 128'(out_valid), 128'(1));
      if (drain_done) begin
        done = 1;
        checkOutput("beat_count", 128'(beats), 128'(len));
        if (len == 0) checkOutput("empty_done_lat", 128'(cyc <= 3), 128'(1));
        else          checkOutput("done_timing", 128'(cyc), 128'(last_cyc + 1));
      end else if (out_valid) begin
        if (beats >= len) begin
          checkOutput("extra_beat", 128'(out_valid), 128'(0));
        end else begin
          checkOutput("out_addr", 128'(out_addr), 128'(beats));
          checkOutput("out_data", out_data, expVec(beats, sh));
          checkOutput("out_last", 128'(out_last), 128'(beats == len - 1));
          if (out_ready) begin
            beats++;
            last_cyc = cyc;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) checkOutput("drain_timeout", 128'(0), 128'(1));
    out_ready = 1'b0;
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_out_valid"},  128'(out_valid),  128'(0));
    checkOutput({pfx, "_out_last"},   128'(out_last),   128'(0));
    checkOutput({pfx, "_drain_done"}, 128'(drain_done), 128'(0));
    checkOutput({pfx, "_busy"},       128'(busy),       128'(0));
    checkOutput({pfx, "_err"},        128'(err),        128'(0));
    checkOutput({pfx, "_out_data"},   out_data,         128'(0));
    checkOutput({pfx, "_out_addr"},   128'(out_addr),   128'(0));
  endtask

  initial begin
    int beats;
    int n;
    int a;
    rst = 1'b1; acc_enable = 1'b0; acc_clear = 1'b0; acc_addr = '0; pe_acc_out = '0;
    conv_done = 1'b0; drain_len = '0; shift = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst = 1'b0;

    // Initialize every entry with a clearing write, then drain the full buffer.
    for (int addr = 0; addr < DEPTH; addr++) begin
      randVals();
      applyStimulus(addr, 1'b1);
    end
    runDrain(DEPTH, $urandom_range(0, 31), 2, 1'b0);

    // Clear then accumulate on consecutive cycles.
    for (int i = 0; i < ARRAY_DIM; i++) pe_vals[i] = 10;
    applyStimulus(5, 1'b1);
    for (int i = 0; i < ARRAY_DIM; i++) pe_vals[i] = 3;
    applyStimulus(5, 1'b0);
    runDrain(6, 0, 0, 1'b0);

    // Forwarding burst on a single address.
    for (int i = 0; i < ARRAY_DIM; i++) pe_vals[i] = 0;
    applyStimulus(0, 1'b1);
    for (int i = 0; i < ARRAY_DIM; i++) pe_vals[i] = 1;
    repeat (4) applyStimulus(0, 1'b0);
    runDrain(1, 0, 0, 1'b0);

    // Requantization corner values.
    for (int i = 0; i < ARRAY_DIM; i++) begin
      case (i % 4)
        0: pe_vals[i] = 1000;
        1: pe_vals[i] = -1000;
        2: pe_vals[i] = 6;
        default: pe_vals[i] = -6;
      endcase
    end
    applyStimulus(0, 1'b1);
    runDrain(1, 2, 0, 1'b0);

    // Backpressure with a toggling ready.
    for (int addr = 0; addr < 8; addr++) begin
      randVals();
      applyStimulus(addr, 1'b1);
    end
    runDrain(8, 4, 1, 1'b0);

    // Write during a drain is dropped and sets the sticky error.
    checkOutput("err_before", 128'(err), 128'(0));
    runDrain(8, 3, 2, 1'b1);
    checkOutput("err_set", 128'(err), 128'(1));
    runDrain(8, 3, 0, 1'b0);
    checkOutput("err_sticky", 128'(err), 128'(1));

    // Empty drain.
    runDrain(0, 0, 0, 1'b0);

    // Reset in the middle of a drain.
    conv_done = 1'b1; drain_len = 11'd8; shift = 5'd0;
    @(posedge clk); #1;
    conv_done = 1'b0;
    out_ready = 1'b1;
    beats = 0;
    n = 0;
    while (beats < 3 && n < 50) begin
      if (out_valid) beats++;
      @(posedge clk); #1;
      n++;
    end
    checkOutput("mid_drain_beats", 128'(beats), 128'(3));
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetState("mid_rst");
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_no_beat", 128'(out_valid), 128'(0));
    out_ready = 1'b0;
    randVals();
    applyStimulus(0, 1'b1);
    randVals();
    applyStimulus(0, 1'b0);
    runDrain(2, $urandom_range(0, 20), 2, 1'b0);

    // Random accumulation rounds with same-address bursts.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(5, 40);
      a = $urandom_range(0, 31);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 2) != 0) a = $urandom_range(0, 31);
        randVals();
        applyStimulus(a, 1'($urandom_range(0, 4) == 0));
      end
      runDrain($urandom_range(1, 40), $urandom_range(0, 24), 2, 1'b0);
    end

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
